// File: rtl/cpu_pkg.sv
// Shared definitions for the microcoded 8-bit CPU: datapath widths,
// microstep limits and the opcode map used by sequencer and decoder.
package cpu_pkg;

    localparam int DATA_W    = 8;
    localparam int STEP_W    = 3;
    localparam int LAST_STEP = 4;

    localparam logic [3:0] NOP = 4'b0000;
    localparam logic [3:0] LDA = 4'b0001;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0011;
    localparam logic [3:0] STA = 4'b0100;
    localparam logic [3:0] LDI = 4'b0101;
    localparam logic [3:0] JMP = 4'b0110;
    localparam logic [3:0] JC  = 4'b0111;
    localparam logic [3:0] JZ  = 4'b1000;
    localparam logic [3:0] OUT = 4'b1110;
    localparam logic [3:0] HLT = 4'b1111;

endpackage

// File: rtl/flags_register.sv
// Z/C flags register: zero detect on the ALU result plus two loadable flops.
module flags_register
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] result,
    input  logic              carry,
    output logic              zf,
    output logic              cf
);

    logic zero;

    assign zero = (result == '0);

    // Capture zero/carry from the current ALU operation when loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            zf <= 1'b0;
            cf <= 1'b0;
        end else if (load) begin
            zf <= zero;
            cf <= carry;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction register, microstep counter, flags and halt latch of the CPU.
// Every strobe from the decoder is registered here; outputs depend only on
// state, so there is no combinational loop through the decoder.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W    = cpu_pkg::DATA_W,
    parameter int STEP_W    = cpu_pkg::STEP_W,
    parameter int LAST_STEP = cpu_pkg::LAST_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_en,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ii,
    input  logic              fi,
    input  logic              hlt,
    input  logic              sr,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic [3:0]        instruction,
    output logic [3:0]        operand,
    output logic [STEP_W-1:0] step,
    output logic              zf,
    output logic              cf,
    output logic              halted,
    output logic              fetch
);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LAST_STEP);

    logic [DATA_W-1:0] ir;
    logic              adv;

    // Once halted nothing advances until reset.
    assign adv = step_en & ~halted;

    // Microstep counter: halt freezes, step-reset or the last step wraps to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            step <= '0;
        end else if (adv) begin
            if (hlt) begin
                step <= step;
            end else if (sr || (step >= STEP_LAST)) begin
                step <= '0;
            end else begin
                step <= step + 1'b1;
            end
        end
    end

    // Instruction register; reset value decodes as NOP with a zero operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir <= {NOP, {(DATA_W-4){1'b0}}};
        end else if (adv && ii) begin
            ir <= bus_in;
        end
    end

    // Sticky halt latch, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (adv && hlt) begin
            halted <= 1'b1;
        end
    end

    flags_register #(
        .DATA_W (DATA_W)
    ) u_flags (
        .clk    (clk),
        .rst    (rst),
        .load   (adv & fi),
        .result (alu_result),
        .carry  (alu_carry),
        .zf     (zf),
        .cf     (cf)
    );

    assign instruction = ir[DATA_W-1 -: 4];
    assign operand     = ir[3:0];
    assign fetch       = (step == '0) && !halted;

endmodule
